// File: rtl/seg_scan_display_pkg.sv
// Shared definitions for the multiplexed 7-segment driver: hex glyphs,
// blank pattern, dp bit position and the output-polarity helper.
package seg_scan_display_pkg;

    // Active-high glyphs, bit0 = segment a
    localparam logic [6:0] SEG_HEX_0 = 7'h3F;
    localparam logic [6:0] SEG_HEX_1 = 7'h06;
    localparam logic [6:0] SEG_HEX_2 = 7'h5B;
    localparam logic [6:0] SEG_HEX_3 = 7'h4F;
    localparam logic [6:0] SEG_HEX_4 = 7'h66;
    localparam logic [6:0] SEG_HEX_5 = 7'h6D;
    localparam logic [6:0] SEG_HEX_6 = 7'h7D;
    localparam logic [6:0] SEG_HEX_7 = 7'h07;
    localparam logic [6:0] SEG_HEX_8 = 7'h7F;
    localparam logic [6:0] SEG_HEX_9 = 7'h6F;
    localparam logic [6:0] SEG_HEX_A = 7'h77;
    localparam logic [6:0] SEG_HEX_B = 7'h7C;
    localparam logic [6:0] SEG_HEX_C = 7'h39;
    localparam logic [6:0] SEG_HEX_D = 7'h5E;
    localparam logic [6:0] SEG_HEX_E = 7'h79;
    localparam logic [6:0] SEG_HEX_F = 7'h71;

    localparam logic [6:0] SEG_BLANK  = 7'h00;
    localparam int         SEG_DP_BIT = 7;

    function automatic logic [7:0] seg_drive(input logic [7:0] pattern,
                                             input logic       active_low);
        return active_low ? ~pattern : pattern;
    endfunction

endpackage

// File: rtl/seg_hex_lut.sv
// Combinational hex nibble to active-high 7-segment glyph lookup.
module seg_hex_lut
    import seg_scan_display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (hex)
            4'h0: seg = SEG_HEX_0;
            4'h1: seg = SEG_HEX_1;
            4'h2: seg = SEG_HEX_2;
            4'h3: seg = SEG_HEX_3;
            4'h4: seg = SEG_HEX_4;
            4'h5: seg = SEG_HEX_5;
            4'h6: seg = SEG_HEX_6;
            4'h7: seg = SEG_HEX_7;
            4'h8: seg = SEG_HEX_8;
            4'h9: seg = SEG_HEX_9;
            4'hA: seg = SEG_HEX_A;
            4'hB: seg = SEG_HEX_B;
            4'hC: seg = SEG_HEX_C;
            4'hD: seg = SEG_HEX_D;
            4'hE: seg = SEG_HEX_E;
            4'hF: seg = SEG_HEX_F;
        endcase
    end

endmodule

// File: rtl/seg_scan_display.sv
// N-digit multiplexed 7-segment driver with guard blanking, leading-zero
// suppression and frame-synchronous data updates.
module seg_scan_display
    import seg_scan_display_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int GUARD          = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_blank,
    input  logic                    load,
    output logic [7:0]              seg_data,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0]      GUARD_END = DIV_W'(GUARD);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [7:0]            SEG_OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] SEL_OFF   = SEL_ACTIVE_LOW ? '1 : '0;

    logic [DIV_W-1:0]        div_cnt;
    logic [IDX_W-1:0]        idx;

    logic [4*NUM_DIGITS-1:0] pend_data;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic                    pend_lz;
    logic                    pend_flag;

    logic [4*NUM_DIGITS-1:0] act_data;
    logic [NUM_DIGITS-1:0]   act_dp;
    logic                    act_lz;

    logic [4*NUM_DIGITS-1:0] nxt_data;
    logic [NUM_DIGITS-1:0]   nxt_dp;
    logic                    nxt_lz;

    logic [NUM_DIGITS-1:0]   blank_mask;
    logic                    zero_run;
    logic [3:0]              cur_nibble;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [6:0]              lut_seg;
    logic [NUM_DIGITS-1:0]   sel_onehot;

    // frame_done is high while the pins show the last cycle of a frame, so the
    // swap lands on the edge that starts slot 0. The decode below reads the
    // post-swap view so the first slot of the new frame already shows new data.
    always_comb begin
        nxt_data = act_data;
        nxt_dp   = act_dp;
        nxt_lz   = act_lz;
        if (frame_done && load) begin
            nxt_data = data_in;
            nxt_dp   = dp_in;
            nxt_lz   = lz_blank;
        end else if (frame_done && pend_flag) begin
            nxt_data = pend_data;
            nxt_dp   = pend_dp;
            nxt_lz   = pend_lz;
        end
    end

    always_comb begin
        blank_mask = '0;
        zero_run   = nxt_lz;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run      = zero_run && (nxt_data[4*i +: 4] == 4'h0);
            blank_mask[i] = zero_run;
        end
    end

    always_comb begin
        cur_nibble = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nibble = nxt_data[4*i +: 4];
                cur_dp     = nxt_dp[i];
                cur_blank  = blank_mask[i];
            end
        end
    end

    assign sel_onehot = NUM_DIGITS'(1) << idx;

    seg_hex_lut u_hex_lut (
        .hex (cur_nibble),
        .seg (lut_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt    <= '0;
            idx        <= '0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_lz    <= 1'b0;
            pend_flag  <= 1'b0;
            act_data   <= '0;
            act_dp     <= '0;
            act_lz     <= 1'b0;
            seg_data   <= SEG_OFF;
            digit_sel  <= SEL_OFF;
            frame_done <= 1'b0;
        end else begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            act_data <= nxt_data;
            act_dp   <= nxt_dp;
            act_lz   <= nxt_lz;

            if (load && !frame_done) begin
                pend_data <= data_in;
                pend_dp   <= dp_in;
                pend_lz   <= lz_blank;
                pend_flag <= 1'b1;
            end else if (frame_done) begin
                pend_flag <= 1'b0;
            end

            seg_data   <= seg_drive({cur_dp, cur_blank ? SEG_BLANK : lut_seg},
                                    SEG_ACTIVE_LOW);
            digit_sel  <= ((div_cnt >= GUARD_END) ? sel_onehot : '0) ^ SEL_OFF;
            frame_done <= (idx == IDX_LAST) && (div_cnt == DIV_LAST);
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed plus random bench for seg_scan_display against a frame-level model.
module tb_seg_scan_display;

    localparam int ND    = 4;
    localparam int SD    = 8;
    localparam int GD    = 2;
    localparam int FRAME = ND * SD;

    localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F,
                                          7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C,
                                          7'h39, 7'h5E, 7'h79, 7'h71};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   data_in = '0;
    logic [3:0]    dp_in = '0;
    logic          lz_blank = 1'b0;
    logic          load = 1'b0;
    logic [7:0]    seg_data;
    logic [3:0]    digit_sel;
    logic          frame_done;

    always #5 clk = ~clk;

    seg_scan_display #(
        .NUM_DIGITS     (ND),
        .SCAN_DIV       (SD),
        .GUARD          (GD),
        .SEG_ACTIVE_LOW (1'b1),
        .SEL_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .lz_blank   (lz_blank),
        .load       (load),
        .seg_data   (seg_data),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    // What the display should be showing, tracked per frame
    logic [15:0] m_act, m_pend;
    logic [3:0]  m_act_dp, m_pend_dp;
    logic        m_act_lz, m_pend_lz, m_flag;
    int          cur_pos;
    bit          cur_valid;
    int          n_asserts = 0;
    int          n_fail = 0;

    function automatic logic [7:0] exp_seg(input int slot);
        int         hi;
        logic [3:0] nib;
        logic [6:0] g;
        hi = -1;
        for (int i = 0; i < ND; i++)
            if (m_act[4*i +: 4] != 4'h0) hi = i;
        nib = m_act[4*slot +: 4];
        g   = (m_act_lz && slot != 0 && slot > hi) ? 7'h00 : GLYPH[nib];
        return ~{m_act_dp[slot], g};
    endfunction

    task automatic check(input string tag, input int pos, input logic [7:0] got,
                         input logic [7:0] exp);
        n_asserts++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s pos=%0d observed=%h expected=%h", tag, pos, got, exp);
        end
    endtask

    task automatic model_reset();
        m_act = '0; m_pend = '0; m_act_dp = '0; m_pend_dp = '0;
        m_act_lz = 1'b0; m_pend_lz = 1'b0; m_flag = 1'b0;
    endtask

    task automatic step(input logic r, input logic ld, input logic [15:0] d,
                        input logic [3:0] dp, input logic lzb);
        bit last;
        int slot, cyc;
        rst = r; load = ld; data_in = d; dp_in = dp; lz_blank = lzb;
        last = cur_valid && ((cur_pos % FRAME) == FRAME - 1);
        if (!r) begin
            if (ld && last) begin
                m_act = d; m_act_dp = dp; m_act_lz = lzb; m_flag = 1'b0;
            end else if (ld) begin
                m_pend = d; m_pend_dp = dp; m_pend_lz = lzb; m_flag = 1'b1;
            end else if (last && m_flag) begin
                m_act = m_pend; m_act_dp = m_pend_dp; m_act_lz = m_pend_lz;
                m_flag = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
            cur_valid = 1'b0;
            check("rst_seg", -1, seg_data, 8'hFF);
            check("rst_sel", -1, {4'h0, digit_sel}, 8'h0F);
            check("rst_fd", -1, {7'h0, frame_done}, 8'h00);
        end else begin
            cur_pos   = cur_valid ? cur_pos + 1 : 0;
            cur_valid = 1'b1;
            slot = (cur_pos / SD) % ND;
            cyc  = cur_pos % SD;
            check("seg", cur_pos, seg_data, exp_seg(slot));
            check("sel", cur_pos, {4'h0, digit_sel},
                  (cyc < GD) ? 8'h0F : {4'h0, ~(4'b0001 << slot)});
            check("frame_done", cur_pos, {7'h0, frame_done},
                  {7'h0, (slot == ND - 1 && cyc == SD - 1)});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 16'($urandom), 4'($urandom), 1'($urandom));
    endtask

    task automatic run_to(input int target);
        int budget;
        budget = 0;
        while (!(cur_valid && (cur_pos % FRAME) == target) && budget < 2 * FRAME) begin
            idle(1);
            budget++;
        end
        n_asserts++;
        assert (budget < 2 * FRAME)
        else begin
            n_fail++;
            $error("FAIL run_to target=%0d observed=timeout expected=reached", target);
        end
    endtask

    initial begin
        logic [15:0] mask;
        cur_pos   = 0;
        cur_valid = 1'b0;
        model_reset();

        step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
        step(1'b1, 1'b1, 16'hBEEF, 4'hF, 1'b0);
        idle(2 * FRAME);

        run_to(13);
        step(1'b0, 1'b1, 16'h12AF, 4'b0100, 1'b0);
        idle(2 * FRAME);

        step(1'b0, 1'b1, 16'h0040, 4'b0000, 1'b1);
        idle(2 * FRAME);
        step(1'b0, 1'b1, 16'h0000, 4'b0000, 1'b1);
        idle(2 * FRAME);

        run_to(10);
        step(1'b0, 1'b1, 16'h9999, 4'b0011, 1'b0);
        run_to(FRAME - 1);
        step(1'b0, 1'b1, 16'h5555, 4'b1000, 1'b0);
        idle(FRAME + 4);

        run_to(5);
        step(1'b0, 1'b1, 16'hAAAA, 4'b0001, 1'b0);
        idle(3);
        step(1'b0, 1'b1, 16'h3C3C, 4'b0010, 1'b0);
        idle(2 * FRAME);

        run_to(8);
        step(1'b0, 1'b1, 16'h7E57, 4'b1111, 1'b0);
        run_to(2 * SD + 5);
        step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
        idle(2 * FRAME);

        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 4))
                0: mask = 16'hFFFF;
                1: mask = 16'h0FFF;
                2: mask = 16'h00FF;
                3: mask = 16'h000F;
                default: mask = 16'h0000;
            endcase
            step($urandom_range(0, 249) == 0, $urandom_range(0, 7) == 0,
                 16'($urandom) & mask, 4'($urandom), 1'($urandom));
        end
        idle(FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
